// File: rtl/load_store_unit.sv
// Load/store unit: drives a byte-addressed data memory port, splitting misaligned
// accesses into byte beats and performing load sign/zero extension itself.
module load_store_unit #(
   parameter int ADDR_W           = 6,
   parameter bit SPLIT_MISALIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_fault,
   output logic              mem_read,
   output logic              mem_write,
   output logic [2:0]        mem_funct3,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

   state_t              state;
   state_t              state_next;
   logic                lat_we;
   logic [2:0]          lat_funct3;
   logic [ADDR_W-1:0]   lat_addr;
   logic [31:0]         lat_wdata;
   logic                lat_fault;
   logic [1:0]          beat;
   logic [31:0]         asm_data;

   logic [1:0]          req_size_m1;
   logic [32:0]         req_end_hi;
   logic                req_misaligned;
   logic                req_fault;
   logic [1:0]          lat_size_m1;
   logic                lat_misaligned;
   logic                last_beat;

   function automatic logic [1:0] size_m1(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   size_m1 = 2'd0;
         2'b01:   size_m1 = 2'd1;
         2'b10:   size_m1 = 2'd3;
         default: size_m1 = 2'd0;
      endcase
   endfunction

   function automatic logic legal_funct3(input logic we, input logic [2:0] f3);
      if (we) begin
         legal_funct3 = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      end else begin
         legal_funct3 = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
      end
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'b000:  extend = {{24{d[7]}}, d[7:0]};
         3'b001:  extend = {{16{d[15]}}, d[15:0]};
         3'b010:  extend = d;
         3'b100:  extend = {24'h000000, d[7:0]};
         3'b101:  extend = {16'h0000, d[15:0]};
         default: extend = 32'h00000000;
      endcase
   endfunction

   // Request legality: any byte of the access beyond the memory top faults (no wrap)
   always_comb begin
      req_size_m1    = size_m1(req_funct3);
      req_end_hi     = ({1'b0, req_addr} + {31'b0, req_size_m1}) >> ADDR_W;
      req_misaligned = |(req_addr[1:0] & req_size_m1);
      req_fault      = !legal_funct3(req_we, req_funct3) || (|req_end_hi) ||
                       (req_misaligned && !SPLIT_MISALIGNED);
   end

   // Latched-request decode for the access phase
   always_comb begin
      lat_size_m1    = size_m1(lat_funct3);
      lat_misaligned = |(lat_addr[1:0] & lat_size_m1);
      last_beat      = !lat_misaligned || (beat == lat_size_m1);
   end

   assign req_ready = (state == IDLE);

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_next = req_fault ? RESP : ACCESS;
            end else begin
               state_next = IDLE;
            end
         end
         ACCESS: begin
            if (last_beat) begin
               state_next = RESP;
            end else begin
               state_next = ACCESS;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Memory port drive; quiet outside ACCESS
   always_comb begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_funct3 = 3'b000;
      mem_addr   = {ADDR_W{1'b0}};
      mem_wdata  = 32'h00000000;
      if (state == ACCESS) begin
         mem_read  = !lat_we;
         mem_write = lat_we;
         if (lat_misaligned) begin
            mem_funct3 = lat_we ? 3'b000 : 3'b100;
            mem_addr   = lat_addr + ADDR_W'(beat);
            mem_wdata  = {24'h000000, lat_wdata[{beat, 3'b000} +: 8]};
         end else begin
            case (lat_size_m1)
               2'd3:    mem_funct3 = 3'b010;
               2'd1:    mem_funct3 = lat_we ? 3'b001 : 3'b101;
               default: mem_funct3 = lat_we ? 3'b000 : 3'b100;
            endcase
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
         end
      end else begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   end

   // State, request latch, beat counter, load assembly and registered response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         lat_we     <= 1'b0;
         lat_funct3 <= 3'b000;
         lat_addr   <= {ADDR_W{1'b0}};
         lat_wdata  <= 32'h00000000;
         lat_fault  <= 1'b0;
         beat       <= 2'd0;
         asm_data   <= 32'h00000000;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 32'h00000000;
         rsp_fault  <= 1'b0;
      end else begin
         state     <= state_next;
         rsp_valid <= (state == RESP);
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_we     <= req_we;
                  lat_funct3 <= req_funct3;
                  lat_addr   <= req_addr[ADDR_W-1:0];
                  lat_wdata  <= req_wdata;
                  lat_fault  <= req_fault;
                  beat       <= 2'd0;
                  asm_data   <= 32'h00000000;
               end
            end
            ACCESS: begin
               if (!lat_we) begin
                  if (lat_misaligned) begin
                     asm_data[{beat, 3'b000} +: 8] <= mem_rdata[7:0];
                  end else begin
                     asm_data <= mem_rdata;
                  end
               end
               beat <= last_beat ? 2'd0 : beat + 2'd1;
            end
            RESP: begin
               rsp_fault <= lat_fault;
               rsp_rdata <= (lat_fault || lat_we) ? 32'h00000000 : extend(lat_funct3, asm_data);
            end
            default: begin
               beat <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// requests scored against a byte-array reference model of memory and responses.
module tb_load_store_unit;
   localparam int AW = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_clr = 1'b1;
   always #5 clk = ~clk;

   logic req_valid_a = 1'b0, req_valid_b = 1'b0, req_we = 1'b0;
   logic [2:0] req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

   logic a_req_ready, a_rsp_valid, a_rsp_fault, a_mem_read, a_mem_write;
   logic [31:0] a_rsp_rdata, a_mem_wdata, a_mem_rdata;
   logic [2:0] a_mem_funct3;
   logic [AW-1:0] a_mem_addr;
   logic b_req_ready, b_rsp_valid, b_rsp_fault, b_mem_read, b_mem_write;
   logic [31:0] b_rsp_rdata, b_mem_wdata, b_mem_rdata;
   logic [2:0] b_mem_funct3;
   logic [AW-1:0] b_mem_addr;

   load_store_unit #(.ADDR_W(AW), .SPLIT_MISALIGNED(1'b1)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(a_req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_fault(a_rsp_fault),
      .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_funct3(a_mem_funct3),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata));

   load_store_unit #(.ADDR_W(AW), .SPLIT_MISALIGNED(1'b0)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(b_req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault),
      .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_funct3(b_mem_funct3),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

   // Byte-addressed memories behind each unit (combinational read, zero-extended)
   logic [7:0] mem_a [64];
   logic [7:0] mem_b [64];
   logic [7:0] ref_a [64];
   logic [7:0] ref_b [64];

   always_comb begin
      a_mem_rdata = 32'h0;
      case (a_mem_funct3[1:0])
         2'b00: a_mem_rdata = {24'h0, mem_a[a_mem_addr]};
         2'b01: a_mem_rdata = {16'h0, mem_a[a_mem_addr + 6'd1], mem_a[a_mem_addr]};
         2'b10: a_mem_rdata = {mem_a[a_mem_addr + 6'd3], mem_a[a_mem_addr + 6'd2],
                               mem_a[a_mem_addr + 6'd1], mem_a[a_mem_addr]};
         default: a_mem_rdata = 32'h0;
      endcase
   end

   always_comb begin
      b_mem_rdata = 32'h0;
      case (b_mem_funct3[1:0])
         2'b00: b_mem_rdata = {24'h0, mem_b[b_mem_addr]};
         2'b01: b_mem_rdata = {16'h0, mem_b[b_mem_addr + 6'd1], mem_b[b_mem_addr]};
         2'b10: b_mem_rdata = {mem_b[b_mem_addr + 6'd3], mem_b[b_mem_addr + 6'd2],
                               mem_b[b_mem_addr + 6'd1], mem_b[b_mem_addr]};
         default: b_mem_rdata = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) begin
            mem_a[i] <= 8'h00;
            mem_b[i] <= 8'h00;
         end
      end else begin
         if (a_mem_write) begin
            for (int i = 0; i < 4; i++)
               if (i < (a_mem_funct3[1:0] == 2'b00 ? 1 : a_mem_funct3[1:0] == 2'b01 ? 2 : 4))
                  mem_a[a_mem_addr + 6'(i)] <= a_mem_wdata[8*i +: 8];
         end
         if (b_mem_write) begin
            for (int i = 0; i < 4; i++)
               if (i < (b_mem_funct3[1:0] == 2'b00 ? 1 : b_mem_funct3[1:0] == 2'b01 ? 2 : 4))
                  mem_b[b_mem_addr + 6'(i)] <= b_mem_wdata[8*i +: 8];
         end
      end
   end

   typedef struct packed {
      logic        we;
      logic [2:0]  f3;
      logic [5:0]  addr;
      logic [31:0] data;
   } beat_t;
   beat_t log_a[$];
   beat_t log_b[$];

   always @(negedge clk) begin
      if (a_mem_read || a_mem_write) log_a.push_back({a_mem_write, a_mem_funct3, a_mem_addr, a_mem_wdata});
      if (b_mem_read || b_mem_write) log_b.push_back({b_mem_write, b_mem_funct3, b_mem_addr, b_mem_wdata});
   end

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   function automatic int ref_size(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit ref_fault(input bit we, input logic [2:0] f3, input logic [31:0] addr, input bit split);
      int n = ref_size(f3);
      bit legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 1'b1;
      if (longint'(addr) + n - 1 > 63) return 1'b1;
      if (!split && (addr % n) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int ref_latency(input bit we, input logic [2:0] f3, input logic [31:0] addr, input bit split);
      int n = ref_size(f3);
      if (ref_fault(we, f3, addr, split)) return 1;
      return ((addr % n) == 0) ? 2 : n + 1;
   endfunction

   function automatic int ref_beats(input bit we, input logic [2:0] f3, input logic [31:0] addr, input bit split);
      int n = ref_size(f3);
      if (ref_fault(we, f3, addr, split)) return 0;
      return ((addr % n) == 0) ? 1 : n;
   endfunction

   function automatic logic [31:0] ref_load(input bit b, input logic [2:0] f3, input logic [31:0] addr);
      longint v = 0;
      int n = ref_size(f3);
      for (int i = 0; i < n; i++)
         v += longint'(b ? ref_b[int'(addr) + i] : ref_a[int'(addr) + i]) << (8 * i);
      if (f3 == 3'd0 && v >= 128) v -= 256;
      if (f3 == 3'd1 && v >= 32768) v -= 65536;
      return v[31:0];
   endfunction

   task automatic ref_store(input bit b, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      for (int i = 0; i < ref_size(f3); i++) begin
         if (b) ref_b[int'(addr) + i] = 8'((wdata >> (8 * i)) & 32'hFF);
         else   ref_a[int'(addr) + i] = 8'((wdata >> (8 * i)) & 32'hFF);
      end
   endtask

   // ---------------- stimulus driver (no checking) ----------------
   task automatic run_op(input bit b, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output logic fault,
                         output int lat, output logic rdy);
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      if (b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
      log_a.delete(); log_b.delete();
      @(posedge clk); #1;
      req_valid_a = 1'b0; req_valid_b = 1'b0;
      lat = 0; rdata = 32'hxxxxxxxx; fault = 1'bx; rdy = 1'bx;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (b ? b_rsp_valid : a_rsp_valid) begin
            lat = i;
            rdata = b ? b_rsp_rdata : a_rsp_rdata;
            fault = b ? b_rsp_fault : a_rsp_fault;
            rdy = b ? b_req_ready : a_req_ready;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", a_req_ready); end
      checks++; if (a_rsp_valid !== 1'b0 || a_rsp_fault !== 1'b0) begin errors++; $display("FAIL reset_rsp: got valid=%b fault=%b want 0/0", a_rsp_valid, a_rsp_fault); end
      checks++; if (a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", a_rsp_rdata); end
      checks++; if ({a_mem_read, a_mem_write, a_mem_funct3, a_mem_addr, a_mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem: got rd=%b wr=%b f3=%b addr=%h wd=%h want all 0", a_mem_read, a_mem_write, a_mem_funct3, a_mem_addr, a_mem_wdata); end
      mem_clr = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got a=%b b=%b want 1", a_req_ready, b_req_ready); end
   endtask

   task automatic test_word();
      logic [31:0] rd; logic ft, rdy; int lat;
      run_op(0, 1, 3'b010, 32'd0, 32'h00000004, rd, ft, lat, rdy);
      ref_store(0, 3'b010, 32'd0, 32'h00000004);
      checks++; if (lat !== 2 || ft !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw0: got lat=%0d fault=%b rdata=%h want 2/0/0", lat, ft, rd); end
      run_op(0, 0, 3'b010, 32'd0, 32'h0, rd, ft, lat, rdy);
      checks++; if (rd !== 32'h00000004) begin errors++; $display("FAIL lw0_data: got %h want 00000004", rd); end
      checks++; if (lat !== 2 || ft !== 1'b0) begin errors++; $display("FAIL lw0_lat: got lat=%0d fault=%b want 2/0", lat, ft); end
      checks++; if (log_a.size() != 1 || log_a[0].f3 !== 3'b010 || log_a[0].we !== 1'b0) begin errors++; $display("FAIL lw0_beat: got beats=%0d want 1 read beat with funct3 010", log_a.size()); end
   endtask

   task automatic test_byte();
      logic [31:0] rd; logic ft, rdy; int lat;
      run_op(0, 1, 3'b000, 32'd5, 32'hABCDEF80, rd, ft, lat, rdy);
      ref_store(0, 3'b000, 32'd5, 32'hABCDEF80);
      checks++; if (mem_a[5] !== 8'h80 || mem_a[6] !== 8'h00) begin errors++; $display("FAIL sb5_mem: got %h %h want 80 00", mem_a[5], mem_a[6]); end
      run_op(0, 0, 3'b000, 32'd5, 32'h0, rd, ft, lat, rdy);
      checks++; if (rd !== 32'hFFFFFF80 || lat !== 2) begin errors++; $display("FAIL lb5: got %h lat=%0d want ffffff80 lat=2", rd, lat); end
      checks++; if (log_a.size() != 1 || log_a[0].f3 !== 3'b100) begin errors++; $display("FAIL lb5_funct3: got beats=%0d want one beat with funct3 100", log_a.size()); end
      run_op(0, 0, 3'b100, 32'd5, 32'h0, rd, ft, lat, rdy);
      checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu5: got %h want 00000080", rd); end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd; logic ft, rdy; int lat;
      logic [31:0] w;
      w = 32'hDEADBEEF;
      run_op(0, 1, 3'b010, 32'd13, w, rd, ft, lat, rdy);
      ref_store(0, 3'b010, 32'd13, w);
      checks++; if (lat !== 5 || log_a.size() != 4) begin errors++; $display("FAIL sw13_beats: got lat=%0d beats=%0d want 5/4", lat, log_a.size()); end
      for (int k = 0; k < 4 && k < log_a.size(); k++) begin
         checks++;
         if (log_a[k].addr !== 6'(13 + k) || log_a[k].data[7:0] !== w[8*k +: 8] || log_a[k].f3 !== 3'b000 || log_a[k].we !== 1'b1) begin
            errors++; $display("FAIL sw13_beat%0d: got addr=%0d data=%h f3=%b want addr=%0d data=%h f3=000", k, log_a[k].addr, log_a[k].data[7:0], log_a[k].f3, 13 + k, w[8*k +: 8]);
         end
      end
      run_op(0, 0, 3'b010, 32'd13, 32'h0, rd, ft, lat, rdy);
      checks++; if (rd !== 32'hDEADBEEF || lat !== 5 || ft !== 1'b0) begin errors++; $display("FAIL lw13: got %h lat=%0d fault=%b want deadbeef 5 0", rd, lat, ft); end
      checks++; if (log_a.size() != 4 || log_a[3].f3 !== 3'b100) begin errors++; $display("FAIL lw13_beats: got %0d beats want 4 with funct3 100", log_a.size()); end
      run_op(0, 0, 3'b001, 32'd15, 32'h0, rd, ft, lat, rdy);
      checks++; if (rd !== 32'hFFFFDEAD || lat !== 3) begin errors++; $display("FAIL lh15: got %h lat=%0d want ffffdead 3", rd, lat); end
   endtask

   task automatic test_faults();
      logic [31:0] rd; logic ft, rdy; int lat;
      bit we_t [9] = '{0, 0, 1, 0, 1, 1, 0, 0, 1};
      logic [2:0] f3_t [9] = '{3'b001, 3'b011, 3'b100, 3'b010, 3'b010, 3'b000, 3'b010, 3'b100, 3'b010};
      logic [31:0] ad_t [9] = '{32'd63, 32'd0, 32'd8, 32'h40, 32'h80000000, 32'd64, 32'd61, 32'd63, 32'd60};
      for (int i = 0; i < 9; i++) begin
         bit ef = ref_fault(we_t[i], f3_t[i], ad_t[i], 1'b1);
         logic [31:0] er = (ef || we_t[i]) ? 32'h0 : ref_load(0, f3_t[i], ad_t[i]);
         int el = ref_latency(we_t[i], f3_t[i], ad_t[i], 1'b1);
         int eb = ref_beats(we_t[i], f3_t[i], ad_t[i], 1'b1);
         logic [31:0] wd = $urandom;
         run_op(0, we_t[i], f3_t[i], ad_t[i], wd, rd, ft, lat, rdy);
         if (we_t[i] && !ef) ref_store(0, f3_t[i], ad_t[i], wd);
         checks++;
         if (ft !== ef || rd !== er || lat !== el || log_a.size() != eb) begin
            errors++; $display("FAIL fault_case%0d: got fault=%b rdata=%h lat=%0d beats=%0d want %b %h %0d %0d", i, ft, rd, lat, log_a.size(), ef, er, el, eb);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd13; req_wdata = 32'h11223344; req_valid_a = 1'b1;
      @(posedge clk); #1; req_valid_a = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1; #1;
      checks++; if (a_mem_write !== 1'b0) begin errors++; $display("FAIL rstmid_wr: got %b want 0", a_mem_write); end
      repeat (2) @(negedge clk) if (a_rsp_valid) seen = 1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (a_rsp_valid) seen = 1; end
      checks++; if (seen) begin errors++; $display("FAIL rstmid_rsp: got rsp_valid=1 want none"); end
      checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", a_req_ready); end
      ref_a[13] = 8'h44; ref_a[14] = 8'h33;
      checks++;
      if (mem_a[13] !== 8'h44 || mem_a[14] !== 8'h33 || mem_a[15] !== ref_a[15] || mem_a[16] !== ref_a[16]) begin
         errors++; $display("FAIL rstmid_mem: got %h %h %h %h want 44 33 %h %h", mem_a[13], mem_a[14], mem_a[15], mem_a[16], ref_a[15], ref_a[16]);
      end
   endtask

   task automatic test_no_split();
      logic [31:0] rd; logic ft, rdy; int lat;
      run_op(1, 1, 3'b010, 32'd4, 32'hCAFEF00D, rd, ft, lat, rdy);
      ref_store(1, 3'b010, 32'd4, 32'hCAFEF00D);
      checks++; if (ft !== 1'b0 || lat !== 2) begin errors++; $display("FAIL nosplit_sw4: got fault=%b lat=%0d want 0 2", ft, lat); end
      run_op(1, 0, 3'b010, 32'd2, 32'h0, rd, ft, lat, rdy);
      checks++; if (ft !== 1'b1 || rd !== 32'h0 || lat !== 1 || log_b.size() != 0) begin errors++; $display("FAIL nosplit_lw2: got fault=%b rdata=%h lat=%0d beats=%0d want 1 0 1 0", ft, rd, lat, log_b.size()); end
      run_op(1, 0, 3'b010, 32'd4, 32'h0, rd, ft, lat, rdy);
      checks++; if (ft !== 1'b0 || rd !== 32'hCAFEF00D || lat !== 2) begin errors++; $display("FAIL nosplit_lw4: got fault=%b rdata=%h lat=%0d want 0 cafef00d 2", ft, rd, lat); end
      run_op(1, 0, 3'b001, 32'd6, 32'h0, rd, ft, lat, rdy);
      checks++; if (rd !== 32'hFFFFCAFE) begin errors++; $display("FAIL nosplit_lh6: got %h want ffffcafe", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d;
      exp_d = ref_load(0, 3'b010, 32'd0);
      @(negedge clk);
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'd0; req_valid_a = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         bit exp_pulse = (k % 3) == 2;
         @(posedge clk); #1;
         if (k == 5) req_valid_a = 1'b0;
         checks++;
         if (a_rsp_valid !== exp_pulse || a_req_ready !== exp_pulse || (exp_pulse && a_rsp_rdata !== exp_d)) begin
            errors++; $display("FAIL b2b_cycle%0d: got valid=%b ready=%b rdata=%h want %b %b %h", k, a_rsp_valid, a_req_ready, a_rsp_rdata, exp_pulse, exp_pulse, exp_d);
         end
      end
      repeat (4) @(posedge clk);
   endtask

   task automatic test_random(input bit b, input int count);
      logic [31:0] rd; logic ft, rdy; int lat;
      for (int i = 0; i < count; i++) begin
         bit we = 1'($urandom_range(0, 1));
         logic [2:0] f3 = 3'($urandom_range(0, 7));
         logic [31:0] ad = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 66));
         logic [31:0] wd = $urandom;
         bit ef = ref_fault(we, f3, ad, !b);
         logic [31:0] er = (ef || we) ? 32'h0 : ref_load(b, f3, ad);
         int el = ref_latency(we, f3, ad, !b);
         int eb = ref_beats(we, f3, ad, !b);
         run_op(b, we, f3, ad, wd, rd, ft, lat, rdy);
         if (we && !ef) ref_store(b, f3, ad, wd);
         checks++;
         if (ft !== ef || rd !== er || lat !== el || (b ? log_b.size() : log_a.size()) != eb || rdy !== 1'b1) begin
            errors++; $display("FAIL rand%0d_%0d: we=%b f3=%b addr=%h got fault=%b rdata=%h lat=%0d beats=%0d want %b %h %0d %0d", b, i, we, f3, ad, ft, rd, lat, b ? log_b.size() : log_a.size(), ef, er, el, eb);
         end
      end
      @(negedge clk);
      for (int j = 0; j < 64; j++) begin
         checks++;
         if ((b ? mem_b[j] : mem_a[j]) !== (b ? ref_b[j] : ref_a[j])) begin
            errors++; $display("FAIL rand%0d_mem%0d: got %h want %h", b, j, b ? mem_b[j] : mem_a[j], b ? ref_b[j] : ref_a[j]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin ref_a[i] = 8'h00; ref_b[i] = 8'h00; end
      repeat (2) @(negedge clk);
      test_reset();
      test_word();
      test_byte();
      test_misaligned();
      test_faults();
      test_reset_mid();
      test_no_split();
      test_back_to_back();
      test_random(1'b0, 60);
      test_random(1'b1, 30);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion within time limit, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Processor-side initiator for the byte-addressed data memory port: it accepts load/store requests from the pipeline and drives MemRead/MemWrite/funct3/addr/data_in toward the memory.
- Aligned accesses complete in one memory beat. Misaligned halfwords and words are split into sequential byte beats.
- The unit performs all load sign/zero extension itself and flags illegal or out-of-range requests.

Parameters:
- ADDR_W, 6, width of memory byte address (memory size = 2^ADDR_W bytes).
- SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into byte beats; 0 = misaligned access faults.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V load/store funct3
- req_addr  input  32  byte address
- req_wdata  input  32  store data, little-endian
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  extended load data (0 for stores/faults)
- rsp_fault  output  1  qualified by rsp_valid
- mem_read  output  1  to memory MemRead
- mem_write  output  1  to memory MemWrite
- mem_funct3  output  3  to memory funct3
- mem_addr  output  ADDR_W  to memory addr
- mem_wdata  output  32  to memory data_in
- mem_rdata  input  32  from memory data_out (combinational read)

Behaviour:
- States: IDLE, ACCESS, RESP. Reset (async) → IDLE, beat counter 0, latched request 0, rsp_valid 0, rsp_rdata 0, rsp_fault 0, all mem_* 0. req_ready = (state==IDLE), so it is 1 after reset.
- Accept: IDLE and req_valid → latch we/funct3/addr/wdata at the edge.
- Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010.
- Size: 1/2/4 bytes for funct3[1:0] = 00/01/10.
- Fault conditions:
  - illegal funct3;
  - req_addr + size − 1 > 2^ADDR_W − 1, including any nonzero addr bit above ADDR_W (no wrap);
  - misaligned with SPLIT_MISALIGNED = 0.
- On fault: go to RESP directly, with no mem_read/mem_write in any cycle. Response is rsp_fault = 1, rsp_rdata = 0.
- Aligned (addr % size == 0): ACCESS lasts one cycle.
  - mem_funct3 = 010 for words; 001 for store halfword; 101 for load halfword; 000 for store byte; 100 for load byte.
  - Loads always use the unsigned/word encodings.
- Misaligned: ACCESS lasts `size` cycles. Beat k (k = 0..size−1) uses mem_addr = addr+k, mem_funct3 = 000 (store) / 100 (load), and mem_wdata[7:0] = wdata byte k.
- mem_* outputs are combinational from state/latched request/beat counter. They are valid only in ACCESS; otherwise all are 0.
- Stores commit at the rising edge ending each ACCESS cycle. Loads capture mem_rdata (or byte k of it) at that edge into an assembly register.
- After the last beat → RESP. In RESP:
  - rsp_valid = 1 for exactly one cycle, rsp_fault = 0;
  - loads return sign-extension for funct3 000/001, zero-extension for 100/101; stores return rsp_rdata = 0;
  - then → IDLE.
- rsp_rdata/rsp_fault are registered and hold between responses.
- Latency from the accept edge to rsp_valid high: aligned 2 cycles; misaligned half 3 cycles; misaligned word 5 cycles; fault 1 cycle.
- Throughput: no back-to-back acceptance. The next accept is possible the cycle after RESP.
- Reset mid-operation: immediate return to IDLE with mem_write deasserted. Bytes already committed stay written (no rollback) and no response is issued.

Test Plan:
- Memory bytes 0..3 = 04 00 00 00; lw addr 0 → mem_read 1 cycle with mem_funct3 = 010; rsp_valid 2 cycles after accept, rsp_rdata = 0x00000004, rsp_fault = 0.
- sb 0x80 at addr 5, then lb 5 → rsp_rdata = 0xFFFFFF80; lbu 5 → 0x00000080; lb beat uses mem_funct3 = 100.
- sw 0xDEADBEEF at addr 13 → 4 write beats at addr 13..16 with data EF, BE, AD, DE; then lw 13 → 0xDEADBEEF, rsp_valid 5 cycles after accept.
- lh at addr 63 (needs bytes 63, 64) → rsp_fault = 1, rsp_rdata = 0, no mem_read/mem_write, 1-cycle latency; same for funct3 011 and for a store with funct3 100.
- Misaligned sw 0x11223344 at 13, assert rst after 2 beats → bytes 13 = 44, 14 = 33, bytes 15/16 unchanged, no rsp_valid, req_ready = 1 after rst releases.
- SPLIT_MISALIGNED = 0: lw addr 2 → rsp_fault = 1 with no memory activity; lw addr 4 still succeeds.
